// File: rtl/sed_monitor.sv
// Control/status stage for the SED primitive: schedules CRC checks, handshakes them, watchdogs a hung check.
// Optional inject path under SED_MONITOR_INJECT_EN; inputs see 2-FF sync latency, SEDENABLE lags EN by 1 cycle.
module sed_monitor #(
    parameter int INTERVAL_W  = 24,
    parameter int TIMEOUT_CYC = 40000000,
    parameter int ERRCNT_W    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  KICK,
    input  logic                  PERIODIC,
    input  logic [INTERVAL_W-1:0] INTERVAL,
    input  logic                  CLR_ERR,
`ifdef SED_MONITOR_INJECT_EN
    input  logic                  INJECT,
`endif
    output logic                  SEDENABLE,
    output logic                  SEDSTART,
    output logic                  SEDFRCERR,
    input  logic                  SEDERR,
    input  logic                  SEDDONE,
    input  logic                  SEDINPROG,
    output logic                  BUSY,
    output logic                  CHK_DONE,
    output logic                  ERR_FLAG,
    output logic [ERRCNT_W-1:0]   ERR_CNT,
    output logic                  TIMEOUT_ERR
`ifdef SED_MONITOR_INJECT_EN
    ,
    output logic                  INJ_SEEN
`endif
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, RUN, CHECK} state_t;

    state_t                state, state_nxt;
    logic [2:0]            done_sync;
    logic [1:0]            err_sync;
    logic [1:0]            inprog_sync;
    logic [WD_W-1:0]       wd_cnt;
    logic [INTERVAL_W-1:0] ivl_cnt;
    logic                  done_rise;
    logic                  err_s;
    logic                  inprog_s;
    logic                  wd_last;
    logic                  start;
    logic                  reload;
    logic                  timeout_hit;
    logic                  check;

    assign done_rise = done_sync[1] & ~done_sync[2];
    assign err_s     = err_sync[1];
    assign inprog_s  = inprog_sync[1];
    assign wd_last   = (wd_cnt == WD_LAST);

    // Abort on EN low outranks the watchdog so an abort never leaves status behind.
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        reload      = 1'b0;
        timeout_hit = 1'b0;
        check       = 1'b0;
        case (state)
            IDLE: begin
                if (EN && (KICK || (PERIODIC && (ivl_cnt == '0))))
                    state_nxt = REQ;
            end
            REQ: begin
                if (!EN) begin
                    state_nxt = IDLE;
                end else if (wd_last) begin
                    state_nxt   = IDLE;
                    reload      = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    start = 1'b1;
                    if (inprog_s)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (!EN) begin
                    state_nxt = IDLE;
                end else if (wd_last) begin
                    state_nxt   = IDLE;
                    reload      = 1'b1;
                    timeout_hit = 1'b1;
                end else if (done_rise) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                check     = 1'b1;
                reload    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign SEDSTART = start;
    assign BUSY     = (state != IDLE);
    assign CHK_DONE = check;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            done_sync   <= '0;
            err_sync    <= '0;
            inprog_sync <= '0;
            SEDENABLE   <= 1'b0;
            wd_cnt      <= '0;
            ivl_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            done_sync   <= {done_sync[1:0], SEDDONE};
            err_sync    <= {err_sync[0], SEDERR};
            inprog_sync <= {inprog_sync[0], SEDINPROG};
            SEDENABLE   <= EN;
            if ((state == REQ || state == RUN) && (state_nxt == REQ || state_nxt == RUN))
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;
            if (reload)
                ivl_cnt <= INTERVAL;
            else if (state == IDLE && PERIODIC && ivl_cnt != '0)
                ivl_cnt <= ivl_cnt - INTERVAL_W'(1);
        end
    end

    // Clear lands first so a simultaneous failing check still counts as one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_FLAG    <= 1'b0;
            ERR_CNT     <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            if (CLR_ERR) begin
                ERR_FLAG    <= 1'b0;
                ERR_CNT     <= '0;
                TIMEOUT_ERR <= 1'b0;
            end
            if (check && err_s) begin
                ERR_FLAG <= 1'b1;
                if (CLR_ERR)
                    ERR_CNT <= ERRCNT_W'(1);
                else if (ERR_CNT != '1)
                    ERR_CNT <= ERR_CNT + ERRCNT_W'(1);
            end
            if (timeout_hit)
                TIMEOUT_ERR <= 1'b1;
        end
    end

`ifdef SED_MONITOR_INJECT_EN
    logic inj_req;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inj_req   <= 1'b0;
            SEDFRCERR <= 1'b0;
            INJ_SEEN  <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == REQ) begin
                SEDFRCERR <= inj_req | INJECT;
                inj_req   <= 1'b0;
            end else if (state == IDLE && INJECT) begin
                inj_req <= 1'b1;
            end
            if (state != IDLE && state_nxt == IDLE)
                SEDFRCERR <= 1'b0;
            if (CLR_ERR)
                INJ_SEEN <= 1'b0;
            if (check && err_s && SEDFRCERR)
                INJ_SEEN <= 1'b1;
        end
    end
`else
    assign SEDFRCERR = 1'b0;
`endif

endmodule
